// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that shares one 8-input mux among 8 requesters.
// Latency: request before edge E is granted after edge E; owner handoff inserts one dead cycle.
// Backpressure: no input handshake; a requester waits at level until granted, en=0 only blocks new grants.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           arbitration enable; does not abort the current owner
//   req[7:0]     request levels, bit i = requester i
//   gnt[7:0]     registered one-hot grant
//   addr[2:0]    registered mux select, index of the current/last owner
//   ncs          registered active-low mux chip select
//   busy         high while a grant is held (~ncs)
//   hold_cnt     cycles elapsed in the current grant (debug)
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       req,
  output logic [7:0]       gnt,
  output logic [2:0]       addr,
  output logic             ncs,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [7:0]       gnt_nxt;
  logic [2:0]       addr_nxt;
  logic             ncs_nxt;
  logic [CNT_W-1:0] hold_nxt;

  logic [7:0]       req_rot;
  logic [2:0]       win_off;
  logic [2:0]       win_idx;
  logic             win_vld;
  logic             release_own;

  // Rotate requests so bit 0 is the requester at ptr; the lowest set bit
  // of the rotated vector is then the round-robin winner.
  always_comb begin
    req_rot = 8'({req, req} >> ptr);
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = 3'(k);
      end
    end
    win_vld = |req;
    win_idx = ptr + win_off;
  end

  // Owner lets go when it drops its request or has used its full time slice.
  assign release_own = ~req[addr] || (TIMEOUT_EN && (hold_cnt == HOLD_LAST));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    addr_nxt  = addr;
    ncs_nxt   = ncs;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE, GAP: begin
        // GAP is the mandatory dead cycle after a release; it then arbitrates like IDLE.
        state_nxt = IDLE;
        gnt_nxt   = 8'h00;
        ncs_nxt   = 1'b1;
        hold_nxt  = '0;
        if (en && win_vld) begin
          state_nxt = OWN;
          gnt_nxt   = 8'h01 << win_idx;
          addr_nxt  = win_idx;
          ncs_nxt   = 1'b0;
          ptr_nxt   = win_idx + 3'd1;
        end
      end
      OWN: begin
        if (release_own) begin
          state_nxt = GAP;
          gnt_nxt   = 8'h00;
          ncs_nxt   = 1'b1;
          hold_nxt  = '0;
        end else if (hold_cnt != CNT_MAX) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 8'h00;
        ncs_nxt   = 1'b1;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      gnt      <= 8'h00;
      addr     <= 3'd0;
      ncs      <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      addr     <= addr_nxt;
      ncs      <= ncs_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign busy = ~ncs;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mux8_rr_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;

  always #5 clk = ~clk;

  // Three instances share the stimulus: MAX_HOLD = 16, 4 and 0.
  logic [7:0] gnt_w  [3];
  logic [2:0] addr_w [3];
  logic       ncs_w  [3];
  logic       busy_w [3];
  logic [7:0] hc_w   [3];

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) u_mh16 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[0]), .addr(addr_w[0]), .ncs(ncs_w[0]), .busy(busy_w[0]), .hold_cnt(hc_w[0]));
  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_mh4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[1]), .addr(addr_w[1]), .ncs(ncs_w[1]), .busy(busy_w[1]), .hold_cnt(hc_w[1]));
  mux8_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_mh0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_w[2]), .addr(addr_w[2]), .ncs(ncs_w[2]), .busy(busy_w[2]), .hold_cnt(hc_w[2]));

  typedef struct packed {
    logic [2:0][7:0] gnt;
    logic [2:0][2:0] addr;
    logic [2:0]      ncs;
    logic [2:0]      busy;
    logic [2:0][7:0] hc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the mux, for how long, and where the next search begins.
  int m_owner [3];
  int m_el    [3];
  int m_ptr   [3];
  int m_last  [3];

  function automatic int hold_limit(int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_el[i]    = 0;
      m_ptr[i]   = 0;
      m_last[i]  = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      int lim;
      lim = hold_limit(i);
      if (m_owner[i] >= 0) begin
        if (!req[m_owner[i]] || (lim != 0 && m_el[i] == lim - 1)) begin
          m_owner[i] = -1;
          m_el[i]    = 0;
        end else begin
          m_el[i] = (m_el[i] < 255) ? m_el[i] + 1 : 255;
        end
      end else if (en && req != 8'h00) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr[i] + k) % 8;
          if (!found && req[c]) begin
            found      = 1'b1;
            m_owner[i] = c;
          end
        end
        m_last[i] = m_owner[i];
        m_ptr[i]  = (m_owner[i] + 1) % 8;
        m_el[i]   = 0;
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    for (int i = 0; i < 3; i++) begin
      s.gnt[i]  = (m_owner[i] >= 0) ? (8'h01 << m_owner[i]) : 8'h00;
      s.addr[i] = 3'(m_last[i]);
      s.ncs[i]  = (m_owner[i] < 0);
      s.busy[i] = (m_owner[i] >= 0);
      s.hc[i]   = 8'(m_el[i]);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2ns after an edge; the model samples them at the edge.
  task automatic step(input logic [7:0] r, input logic e);
    req = r;
    en  = e;
    @(posedge clk);
    model_edge();
    q.push_back(snapshot());
    #2;
  endtask

  task automatic steps(input logic [7:0] r, input logic e, input int n);
    for (int c = 0; c < n; c++) step(r, e);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset_check();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_gnt%0d", i), 32'(gnt_w[i]), 32'h0);
      chk($sformatf("async_rst_ncs%0d", i), 32'(ncs_w[i]), 32'h1);
      chk($sformatf("async_rst_busy%0d", i), 32'(busy_w[i]), 32'h0);
      chk($sformatf("async_rst_hold%0d", i), 32'(hc_w[i]), 32'h0);
    end
    q.delete();
    model_reset();
    #1;
  endtask

  // Monitor: every falling edge the registered outputs are compared with the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        tests++;
        if ({gnt_w[i], addr_w[i], ncs_w[i], busy_w[i], hc_w[i]} !==
            {mon_e.gnt[i], mon_e.addr[i], mon_e.ncs[i], mon_e.busy[i], mon_e.hc[i]}) begin
          fails++;
          $display("FAIL sb_inst%0d t=%0t gnt/addr/ncs/busy/hold got %h/%0d/%b/%b/%0d expected %h/%0d/%b/%b/%0d",
                   i, $time, gnt_w[i], addr_w[i], ncs_w[i], busy_w[i], hc_w[i],
                   mon_e.gnt[i], mon_e.addr[i], mon_e.ncs[i], mon_e.busy[i], mon_e.hc[i]);
        end
      end
    end
  end

  logic [7:0] rq;

  initial begin
    model_reset();

    // Reset held with every requester asserting.
    rst_n = 1'b0;
    steps(8'hFF, 1'b1, 3);
    chk("rst_gnt", 32'(gnt_w[0]), 32'h0);
    chk("rst_addr", 32'(addr_w[0]), 32'h0);
    chk("rst_ncs", 32'(ncs_w[0]), 32'h1);
    chk("rst_busy", 32'(busy_w[0]), 32'h0);
    rst_n = 1'b1;
    step(8'hFF, 1'b1);
    chk("first_grant", 32'(gnt_w[0]), 32'h01);
    chk("first_ncs", 32'(ncs_w[0]), 32'h0);
    steps(8'h00, 1'b1, 4);

    // Single requester for five cycles.
    steps(8'h04, 1'b1, 5);
    steps(8'h00, 1'b1, 4);

    // Two requesters alternating from a fresh pointer.
    async_reset_check();
    step(8'h00, 1'b1);
    rst_n = 1'b1;
    steps(8'h81, 1'b1, 30);
    steps(8'h00, 1'b1, 3);

    // Sole requester hitting the timeout repeatedly.
    steps(8'h20, 1'b1, 40);
    steps(8'h00, 1'b1, 3);

    // Enable dropped mid-grant, then reset mid-grant.
    steps(8'h08, 1'b1, 3);
    steps(8'h08, 1'b0, 6);
    steps(8'h00, 1'b0, 2);
    steps(8'hFF, 1'b0, 4);
    steps(8'h08, 1'b1, 3);
    chk("pre_reset_busy", 32'(busy_w[0]), 32'(m_owner[0] >= 0));
    async_reset_check();
    step(8'h08, 1'b1);
    rst_n = 1'b1;
    steps(8'h00, 1'b1, 3);

    // Long request: only the MAX_HOLD=0 instance keeps it, its counter saturates.
    steps(8'h10, 1'b1, 300);
    chk("sat_hold", 32'(hc_w[2]), 32'd255);
    steps(8'h00, 1'b1, 3);

    // Random request levels with occasional enable drops and resets.
    rq = 8'h00;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      step(rq, $urandom_range(0, 15) != 0);
      if ($urandom_range(0, 599) == 0) begin
        async_reset_check();
        step(rq, 1'b1);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
